ddr_request_arbiter: RTL and testbench

//  Shares the single DDRAM burst port (Avalon-MM style: rd/wr, addr, burstcnt, waitrequest, readdatavalid)

---
 rtl/ddr_arb_pkg.sv | 17 +
 rtl/ddr_arb_picker.sv | 51 +++++
 rtl/ddr_request_arbiter.sv | 154 +++++++++++++++
 tb/tb_ddr_request_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR request arbiter.
// Build option DDR_ARB_ROUND_ROBIN_EN selects rotating instead of fixed priority.
package ddr_arb_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } ddr_arb_state_t;

endpackage

// File: rtl/ddr_arb_picker.sv
// One-hot winner selection among pending requesters.
// DDR_ARB_ROUND_ROBIN_EN: rotate priority past the last winner; otherwise lowest index wins.
module ddr_arb_picker
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_last,
  output logic [NUM_REQ-1:0] o_win
);

  logic w_found;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  int w_last_idx;

  // An all-zero last-grant vector (after reset) behaves as if the top index won last.
  always_comb begin
    o_win      = '0;
    w_found    = 1'b0;
    w_last_idx = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_last[i]) w_last_idx = i;
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && (j == ((w_last_idx + k) % NUM_REQ))) begin
          o_win[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_win[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ddr_request_arbiter.sv
// Shares one Avalon-style DDR burst port between NUM_REQ masters, one whole burst per grant.
// Build option DDR_ARB_ROUND_ROBIN_EN enables rotating priority in ddr_arb_picker.
module ddr_request_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_rd,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*BURST_W-1:0]    req_burst,
  input  logic [NUM_REQ*DATA_W-1:0]     req_din,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_mask,
  output logic [NUM_REQ-1:0]            req_wait,
  output logic [NUM_REQ-1:0]            req_valid,
  output logic [DATA_W-1:0]             req_dout,
  output logic                          ddr_rd,
  output logic                          ddr_wr,
  output logic [ADDR_W-1:0]             ddr_addr,
  output logic [BURST_W-1:0]            ddr_burst,
  output logic [DATA_W-1:0]             ddr_din,
  output logic [DATA_W/8-1:0]           ddr_mask,
  input  logic                          ddr_wait_req,
  input  logic                          ddr_valid,
  input  logic [DATA_W-1:0]             ddr_dout,
  output logic                          busy
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  ddr_arb_state_t       r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_last;
  logic [ADDR_W-1:0]    r_addr;
  logic [BURST_W-1:0]   r_burst;
  logic [BURST_W-1:0]   r_cnt;

  logic [NUM_REQ-1:0]   w_cand;
  logic [NUM_REQ-1:0]   w_win;
  logic [ADDR_W-1:0]    w_win_addr;
  logic [BURST_W-1:0]   w_win_burst;
  logic                 w_win_rd;
  logic                 w_g_wr;
  logic [DATA_W-1:0]    w_g_din;
  logic [MASK_W-1:0]    w_g_mask;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_rd_beat;
  logic                 w_beat;
  logic [BURST_W-1:0]   w_cnt_inc;
  logic                 w_last_beat;

  assign w_cand = req_rd | req_wr;

  ddr_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req  (w_cand),
    .i_last (r_last),
    .o_win  (w_win)
  );

  // Grant vectors are one-hot, so plain selection is enough for the muxes.
  always_comb begin
    w_win_addr  = '0;
    w_win_burst = '0;
    w_g_din     = '0;
    w_g_mask    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) begin
        w_win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_win_burst = req_burst[i*BURST_W +: BURST_W];
      end
      if (r_grant[i]) begin
        w_g_din  = req_din[i*DATA_W +: DATA_W];
        w_g_mask = req_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  assign w_win_rd    = |(w_win & req_rd);
  assign w_g_wr      = |(r_grant & req_wr);
  assign w_rd_acc    = (r_state == RD_CMD) && !ddr_wait_req;
  assign w_wr_acc    = (r_state == WR) && w_g_wr && !ddr_wait_req;
  assign w_rd_beat   = ddr_valid && ((r_state == RD_DATA) || w_rd_acc);
  assign w_beat      = w_rd_beat || w_wr_acc;
  assign w_cnt_inc   = r_cnt + BURST_ONE;
  assign w_last_beat = w_beat && (w_cnt_inc == r_burst);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_cand) begin
            r_grant <= w_win;
            r_last  <= w_win;
            r_cnt   <= '0;
            r_state <= w_win_rd ? RD_CMD : WR;
          end
        end
        RD_CMD: begin
          if (w_rd_acc) begin
            if (w_beat) r_cnt <= w_cnt_inc;
            r_state <= w_last_beat ? IDLE : RD_DATA;
          end
        end
        RD_DATA, WR: begin
          if (w_beat) begin
            r_cnt <= w_cnt_inc;
            if (w_last_beat) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Burst parameters are captured at grant time; a zero length means one beat.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && |w_cand) begin
      r_addr  <= w_win_addr;
      r_burst <= (w_win_burst == '0) ? BURST_ONE : w_win_burst;
    end
  end

  always_comb begin
    req_wait = '1;
    if (w_rd_acc) begin
      req_wait = ~r_grant;
    end else if (r_state == WR) begin
      req_wait = ~r_grant | (r_grant & {NUM_REQ{ddr_wait_req}});
    end
  end

  assign req_valid = w_rd_beat ? r_grant : '0;
  assign req_dout  = ddr_dout;
  assign ddr_rd    = (r_state == RD_CMD);
  assign ddr_wr    = (r_state == WR) && w_g_wr;
  assign ddr_addr  = r_addr;
  assign ddr_burst = r_burst;
  assign ddr_din   = w_g_din;
  assign ddr_mask  = w_g_mask;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ddr_request_arbiter.sv
// Randomized scoreboard bench for ddr_request_arbiter with a DDR slave model and requester drivers.
// Honours DDR_ARB_ROUND_ROBIN_EN in its arbitration reference.
module tb_ddr_request_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int MW  = 8;
  localparam int OPS = 25;
  localparam int LIMIT = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_rd, req_wr, req_wait, req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_burst;
  logic [NR*DW-1:0]  req_din;
  logic [NR*MW-1:0]  req_mask;
  logic [DW-1:0]     req_dout;
  logic              ddr_rd, ddr_wr, ddr_wait_req, ddr_valid, busy;
  logic [AW-1:0]     ddr_addr;
  logic [BW-1:0]     ddr_burst;
  logic [DW-1:0]     ddr_din, ddr_dout;
  logic [MW-1:0]     ddr_mask;

  ddr_request_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_burst(req_burst),
    .req_din(req_din), .req_mask(req_mask), .req_wait(req_wait), .req_valid(req_valid),
    .req_dout(req_dout), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
    .ddr_burst(ddr_burst), .ddr_din(ddr_din), .ddr_mask(ddr_mask),
    .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout), .busy(busy)
  );

  typedef struct { logic [63:0] d; bit last; } rexp_t;
  typedef struct { logic [119:0] v; bit last; } wexp_t;

  rexp_t       rdq[NR][$];
  wexp_t       wq[NR][$];
  logic [63:0] retq[$];

  int n_vec = 0;
  int n_err = 0;

  bit          mon_en = 1'b0;
  bit          nxt_wait = 1'b0, nxt_valid = 1'b0;
  logic [63:0] nxt_dout = '0;
  bit          idle_due = 1'b0, arb_due = 1'b0, exp_rd = 1'b0;
  int          exp_id = 0, mlast = NR - 1, wbeat = 0;

  int          phase[NR], gap[NR], left[NR], beat[NR], nb[NR], done_ops[NR];
  bit          ack[NR];
  logic [63:0] wd[NR][8];
  logic [7:0]  wm[NR][8];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Slave memory contents: derived from the address so any address mistake shows in data.
  function automatic logic [63:0] rdata(input logic [31:0] a, input int b);
    return {a, a + 32'(b) * 32'h9E37_79B9};
  endfunction

  // Arbitration rule from the block description, independent of the RTL structure.
  function automatic int pick(input logic [NR-1:0] c, input int last);
`ifdef DDR_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (last + k) % NR;
      if (c[j]) return j;
    end
`else
    for (int i = 0; i < NR; i++) if (c[i]) return i;
    if (last < 0) return -1;
`endif
    return -1;
  endfunction

  // Monitor: DDR-side slave bookkeeping and all scoreboard comparisons.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [NR-1:0] cand;
        cand = req_rd | req_wr;
        if (idle_due) begin
          check("idle_after_burst", {127'd0, busy}, 128'd0);
          idle_due = 1'b0;
        end
        if (arb_due) begin
          check("grant", {124'd0, busy, ddr_addr[31:30], ddr_rd}, {124'd0, 1'b1, 2'(exp_id), exp_rd});
          arb_due = 1'b0;
        end
        if (!busy && cand != '0) begin
          exp_id  = pick(cand, mlast);
          mlast   = exp_id;
          exp_rd  = req_rd[exp_id];
          arb_due = 1'b1;
          wbeat   = 0;
        end
        if (ddr_rd && !ddr_wait_req) begin
          for (int b = 0; b < int'(ddr_burst); b++) retq.push_back(rdata(ddr_addr, b));
        end
        if (ddr_wr && !ddr_wait_req) begin
          int id;
          id = int'(ddr_addr[31:30]);
          if (id >= NR || wq[id].size() == 0) begin
            check("unexpected_write", {8'd0, ddr_addr, ddr_burst, ddr_din, ddr_mask, 8'(wbeat)}, 128'd0);
          end else begin
            wexp_t e;
            e = wq[id].pop_front();
            check("write_beat", {8'd0, ddr_addr, ddr_burst, ddr_din, ddr_mask, 8'(wbeat)}, {8'd0, e.v});
            if (e.last) idle_due = 1'b1;
          end
          wbeat++;
        end
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i]) begin
            if (rdq[i].size() == 0) begin
              check("unexpected_valid", {64'd0, req_dout}, {64'd0, 64'hDEAD});
            end else begin
              rexp_t r;
              r = rdq[i].pop_front();
              check("read_beat", {64'(i), req_dout}, {64'(i), r.d});
              if (r.last) idle_due = 1'b1;
            end
          end
        end
        if ($countones(req_valid) > 1) check("valid_onehot", {125'd0, req_valid}, 128'd0);
        nxt_wait  = ($urandom_range(0, 99) < 30);
        nxt_valid = 1'b0;
        nxt_dout  = {$urandom, $urandom};
        if (retq.size() > 0 && $urandom_range(0, 99) < 70) begin
          nxt_valid = 1'b1;
          nxt_dout  = retq.pop_front();
        end else if (!busy && cand == '0 && $urandom_range(0, 99) < 20) begin
          nxt_valid = 1'b1;
        end
      end
    end
  end

  task automatic start_op(input int i);
    int kind, bl, n;
    logic [31:0] a;
    kind = $urandom_range(0, 9);
    bl   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
    if (i == 2 && done_ops[i] == 1) begin
      kind = 0;
      bl   = 255;
    end
    a = $urandom;
    a[31:30] = 2'(i);
    n = (bl == 0) ? 1 : bl;
    nb[i] = n;
    beat[i] = 0;
    req_addr[i*AW +: AW]  = a;
    req_burst[i*BW +: BW] = 8'(bl);
    if (kind <= 4 || kind == 9) begin
      for (int b = 0; b < n; b++) begin
        rexp_t r;
        r.d = rdata(a, b);
        r.last = (b == n - 1);
        rdq[i].push_back(r);
      end
    end
    if (kind >= 5) begin
      for (int b = 0; b < n; b++) begin
        wexp_t w;
        wd[i][b] = {$urandom, $urandom};
        wm[i][b] = 8'($urandom);
        w.v = {a, 8'(n), wd[i][b], wm[i][b], 8'(b)};
        w.last = (b == n - 1);
        wq[i].push_back(w);
      end
      req_din[i*DW +: DW]  = wd[i][0];
      req_mask[i*MW +: MW] = wm[i][0];
    end
    req_rd[i] = (kind <= 4 || kind == 9);
    req_wr[i] = (kind >= 5);
    phase[i]  = (kind <= 4) ? 1 : (kind == 9) ? 2 : 3;
  endtask

  task automatic finish_op(input int i);
    phase[i] = 0;
    left[i]--;
    done_ops[i]++;
    gap[i] = $urandom_range(0, 3);
  endtask

  task automatic step_req(input int i);
    case (phase[i])
      0: if (gap[i] > 0) gap[i]--; else if (left[i] > 0) start_op(i);
      1: if (ack[i]) begin req_rd[i] = 1'b0; finish_op(i); end
      2: if (ack[i]) begin req_rd[i] = 1'b0; phase[i] = 3; end
      default: begin
        if (ack[i]) begin
          beat[i]++;
          if (beat[i] == nb[i]) begin
            req_wr[i] = 1'b0;
            finish_op(i);
          end else begin
            req_din[i*DW +: DW]  = wd[i][beat[i]];
            req_mask[i*MW +: MW] = wm[i][beat[i]];
            req_wr[i] = ($urandom_range(0, 4) != 0);
          end
        end else if (!req_wr[i]) begin
          req_wr[i] = 1'b1;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit step);
    @(negedge clk);
    for (int i = 0; i < NR; i++) ack[i] = !req_wait[i] && (req_rd[i] || req_wr[i]);
    @(posedge clk);
    #1;
    ddr_wait_req = nxt_wait;
    ddr_valid    = nxt_valid;
    ddr_dout     = nxt_dout;
    if (step) for (int i = 0; i < NR; i++) step_req(i);
  endtask

  function automatic bit all_done();
    if (busy || retq.size() != 0) return 1'b0;
    for (int i = 0; i < NR; i++)
      if (left[i] != 0 || phase[i] != 0 || rdq[i].size() != 0 || wq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int cyc, qsum;
    logic [31:0] a;
    rst_n = 1'b0;
    req_rd = '0; req_wr = '0; req_addr = '0; req_burst = '0; req_din = '0; req_mask = '0;
    ddr_wait_req = 1'b0; ddr_valid = 1'b0; ddr_dout = '0;
    for (int i = 0; i < NR; i++) begin
      phase[i] = 0; gap[i] = 0; left[i] = 0; beat[i] = 0; nb[i] = 1; done_ops[i] = 0; ack[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  {127'd0, busy}, 128'd0);
    check("reset_wait",  {125'd0, req_wait}, {125'd0, 3'b111});
    check("reset_valid", {125'd0, req_valid}, 128'd0);
    check("reset_rdwr",  {126'd0, ddr_rd, ddr_wr}, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) left[i] = OPS;
    mon_en = 1'b1;

    cyc = 0;
    while (!all_done() && cyc < LIMIT) begin
      cycle(1'b1);
      cyc++;
    end
    if (cyc >= LIMIT) check("random_phase_timeout", 128'(cyc), 128'(LIMIT - 1));
    repeat (4) cycle(1'b0);
    qsum = retq.size();
    for (int i = 0; i < NR; i++) qsum += rdq[i].size() + wq[i].size();
    check("queues_drained", 128'(qsum), 128'd0);

    // Reset in the middle of an 8-beat read: two beats delivered, six arrive after reset.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    ddr_wait_req = 1'b0; ddr_valid = 1'b0;
    a = 32'h4000_1000;
    req_rd = 3'b010;
    req_addr[AW +: AW] = a;
    req_burst[BW +: BW] = 8'd8;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_test_cmd", {126'd0, ddr_rd, busy}, {126'd0, 2'b11});
    @(posedge clk);
    #1;
    req_rd = '0;
    ddr_valid = 1'b1;
    ddr_dout = rdata(a, 0);
    @(negedge clk);
    check("rst_test_beat0", {61'd0, req_valid, req_dout}, {61'd0, 3'b010, rdata(a, 0)});
    @(posedge clk);
    #1;
    ddr_dout = rdata(a, 1);
    @(negedge clk);
    check("rst_test_beat1", {61'd0, req_valid, req_dout}, {61'd0, 3'b010, rdata(a, 1)});
    @(posedge clk);
    #1;
    ddr_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ddr_valid = 1'b1;
      ddr_dout  = {$urandom, $urandom};
      @(negedge clk);
      check("post_reset_outputs", {119'd0, busy, ddr_rd, ddr_wr, req_wait, req_valid},
            {119'd0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000});
      @(posedge clk);
      #1;
    end
    ddr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
